fetch_prefetch: RTL

Parametrised instruction-fetch stage with a prefetch queue, for the pipelined CPU. It keeps up to MAX_OUTST in-order read requests in flight on a valid/ready memory port, which the cache/AXI bridge serves. Returned instructions, tagged with their PC, are buffered in a QDEPTH-entry queue and handed to ID through a valid/ready handshake. A branch redirect or an exception flushes the queue and discards any stale in-flight responses.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 75 +++++++
 rtl/fetch_prefetch.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg : shared defaults and types for the instruction-fetch stage (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam logic [31:0] DEF_START_ADDR = 32'h0000_0034;
  localparam int unsigned REDIR_W        = DEF_ADDR_W + 1;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] inst;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo : first-word fall-through FIFO with synchronous flush (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    // Flush overrides any push or pop issued in the same cycle.
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/fetch_prefetch.sv
// ----------------------------------------------------------------------------
// fetch_prefetch : IF stage with in-order request tracking and prefetch queue (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W     = DEF_ADDR_W,
  parameter int unsigned       DATA_W     = DEF_DATA_W,
  parameter int unsigned       QDEPTH     = 4,
  parameter int unsigned       MAX_OUTST  = 2,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(DEF_START_ADDR)
) (
  input  logic                       clk,
  input  logic                       resetn,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [ADDR_W-1:0]          mem_req_addr,
  input  logic                       mem_rsp_valid,
  input  logic [DATA_W-1:0]          mem_rsp_data,
  input  logic [ADDR_W:0]            jbr_bus,
  input  logic [ADDR_W:0]            exc_bus,
  output logic                       IF_over,
  input  logic                       next_fetch,
  output logic [ADDR_W+DATA_W-1:0]   IF_ID_bus,
  output logic [ADDR_W-1:0]          IF_pc,
  output logic [DATA_W-1:0]          IF_inst,
  output logic [$clog2(MAX_OUTST):0] outst_cnt
);

  localparam int unsigned OC_W  = $clog2(MAX_OUTST) + 1;
  localparam int unsigned QC_W  = $clog2(QDEPTH) + 1;
  localparam int unsigned SUM_W = QC_W + 1;
  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [OC_W-1:0]   outst_q, outst_d;
  logic [OC_W-1:0]   drop_q, drop_d;
  logic [OC_W-1:0]   live_outst;

  logic              redir;
  logic [ADDR_W-1:0] redir_tgt;
  logic              accept, rsp_live, id_pop;

  logic [ADDR_W-1:0] tag_head;
  logic [OC_W-1:0]   tag_count;
  logic              tag_full, tag_empty;

  logic [ENT_W-1:0]  q_head;
  logic [QC_W-1:0]   q_count;
  logic              q_full, q_empty;

  logic              sink_unused;

  assign redir     = exc_bus[ADDR_W] | jbr_bus[ADDR_W];
  assign redir_tgt = exc_bus[ADDR_W] ? exc_bus[ADDR_W-1:0] : jbr_bus[ADDR_W-1:0];

  // Reserving a queue slot per live request keeps responses free of back-pressure.
  assign live_outst    = outst_q - drop_q;
  assign mem_req_valid = resetn & ~redir
                       & (live_outst < OC_W'(MAX_OUTST))
                       & ((SUM_W'(live_outst) + SUM_W'(q_count)) < SUM_W'(QDEPTH));
  assign mem_req_addr  = fetch_pc_q;
  assign accept        = mem_req_valid & mem_req_ready;
  assign rsp_live      = mem_rsp_valid & (drop_q == '0);
  assign id_pop        = IF_over & next_fetch;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q + OC_W'(accept) - OC_W'(mem_rsp_valid);
    drop_d     = drop_q;
    if (redir) begin
      fetch_pc_d = redir_tgt;
      drop_d     = outst_q - OC_W'(mem_rsp_valid);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      if (mem_rsp_valid && drop_q != '0) drop_d = drop_q - OC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc_q <= START_ADDR;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (accept),
    .data_i  (fetch_pc_q),
    .pop_i   (rsp_live),
    .flush_i (redir),
    .data_o  (tag_head),
    .count_o (tag_count),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (QDEPTH)
  ) u_prefetch_q (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (rsp_live),
    .data_i  ({tag_head, mem_rsp_data}),
    .pop_i   (id_pop),
    .flush_i (redir),
    .data_o  (q_head),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign IF_over   = ~q_empty;
  assign IF_ID_bus = q_empty ? '0 : q_head;
  assign IF_pc     = IF_ID_bus[ENT_W-1:DATA_W];
  assign IF_inst   = IF_ID_bus[DATA_W-1:0];
  assign outst_cnt = outst_q;

  assign sink_unused = ^{tag_count, tag_full, tag_empty, q_full};

endmodule

`default_nettype wire
